// File: rtl/y_sram_port_arbiter.sv
// Y-buffer SRAM port arbiter: two writers share the single write port, and
// three readers share the two read ports. Round-robin grants, registered SRAM
// controls, and read data returned per requester after a fixed latency.
module y_sram_port_arbiter #(
    parameter int DEPTH    = 1800,
    parameter int AW       = 11,
    parameter int DW       = 256,
    parameter int READ_LAT = 1     // must be >= 1
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [1:0]        i_wr_req,
    input  logic [2*AW-1:0]   i_wr_addr,
    input  logic [2*DW-1:0]   i_wr_data,
    output logic [1:0]        o_wr_gnt,
    input  logic [2:0]        i_rd_req,
    input  logic [3*AW-1:0]   i_rd_addr,
    output logic [2:0]        o_rd_gnt,
    output logic [2:0]        o_rd_valid,
    output logic [3*DW-1:0]   o_rd_data,
    output logic              o_addr_err,
    output logic              o_sram_we,
    output logic [AW-1:0]     o_sram_waddr,
    output logic [DW-1:0]     o_sram_wdata,
    output logic [AW-1:0]     o_sram_raddr1,
    output logic [AW-1:0]     o_sram_raddr2,
    input  logic [DW-1:0]     i_sram_rdata1,
    input  logic [DW-1:0]     i_sram_rdata2
);

    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    // Per-port tag: owning reader and whether the data must be forced to zero
    typedef struct packed {
        logic       vld;
        logic [1:0] id;
        logic       zero;
    } tag_t;

    logic              r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic [1:0]        w_wr_gnt;
    logic [AW-1:0]     w_wr_addr;
    logic [DW-1:0]     w_wr_data;
    logic              w_wr_legal;
    logic              w_wr_bad;
    logic [2:0]        w_rd_gnt;
    logic [1:0]        w_rd_ptr_nxt;
    logic              w_p1_vld, w_p2_vld;
    logic [1:0]        w_p1_id, w_p2_id;
    logic [AW-1:0]     w_p1_addr, w_p2_addr;
    logic              w_p1_legal, w_p2_legal;
    logic              r_sram_we;
    logic [AW-1:0]     r_sram_waddr, r_sram_raddr1, r_sram_raddr2;
    logic [DW-1:0]     r_sram_wdata;
    logic              r_addr_err;
    logic [3*DW-1:0]   r_rd_data;
    tag_t              r_tag1 [0:READ_LAT];
    tag_t              r_tag2 [0:READ_LAT];

    // Write arbitration: contention alternates, a lone requester always wins
    always_comb begin
        w_wr_gnt = i_wr_req;
        if (&i_wr_req) w_wr_gnt = r_wr_ptr ? 2'b10 : 2'b01;
        if (!i_reset_n) w_wr_gnt = 2'b00;
        w_wr_addr  = w_wr_gnt[1] ? i_wr_addr[AW +: AW] : i_wr_addr[0 +: AW];
        w_wr_data  = w_wr_gnt[1] ? i_wr_data[DW +: DW] : i_wr_data[0 +: DW];
        w_wr_legal = (|w_wr_gnt) && ({1'b0, w_wr_addr} < LIMIT);
        w_wr_bad   = (|w_wr_gnt) && !({1'b0, w_wr_addr} < LIMIT);
    end

    // Read arbitration and port mapping: only a full house needs rotation
    always_comb begin
        w_rd_gnt     = i_rd_req;
        w_rd_ptr_nxt = r_rd_ptr;
        if (&i_rd_req) begin
            case (r_rd_ptr)
                2'd0:    begin w_rd_gnt = 3'b011; w_rd_ptr_nxt = 2'd2; end
                2'd1:    begin w_rd_gnt = 3'b110; w_rd_ptr_nxt = 2'd0; end
                default: begin w_rd_gnt = 3'b101; w_rd_ptr_nxt = 2'd1; end
            endcase
        end
        if (!i_reset_n) w_rd_gnt = 3'b000;
        w_p1_vld  = 1'b0; w_p1_id = 2'd0; w_p1_addr = '0;
        w_p2_vld  = 1'b0; w_p2_id = 2'd0; w_p2_addr = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_rd_gnt[i]) begin
                if (!w_p1_vld) begin
                    w_p1_vld = 1'b1; w_p1_id = 2'(i); w_p1_addr = i_rd_addr[i*AW +: AW];
                end else begin
                    w_p2_vld = 1'b1; w_p2_id = 2'(i); w_p2_addr = i_rd_addr[i*AW +: AW];
                end
            end
        end
        w_p1_legal = {1'b0, w_p1_addr} < LIMIT;
        w_p2_legal = {1'b0, w_p2_addr} < LIMIT;
    end

    // Round-robin pointers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 2'd0;
        end else begin
            if (&i_wr_req) r_wr_ptr <= ~r_wr_ptr;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // SRAM-side registers; an illegal write never raises the enable and
    // an illegal read leaves the port address untouched
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sram_we     <= 1'b0;
            r_sram_waddr  <= '0;
            r_sram_wdata  <= '0;
            r_sram_raddr1 <= '0;
            r_sram_raddr2 <= '0;
            r_addr_err    <= 1'b0;
        end else begin
            r_sram_we <= w_wr_legal;
            if (w_wr_legal) begin
                r_sram_waddr <= w_wr_addr;
                r_sram_wdata <= w_wr_data;
            end
            if (w_p1_vld && w_p1_legal) r_sram_raddr1 <= w_p1_addr;
            if (w_p2_vld && w_p2_legal) r_sram_raddr2 <= w_p2_addr;
            r_addr_err <= w_wr_bad || (w_p1_vld && !w_p1_legal) || (w_p2_vld && !w_p2_legal);
        end
    end

    // Tag shift registers: stage k holds the grant from k+1 edges ago
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k <= READ_LAT; k++) begin
                r_tag1[k] <= '0;
                r_tag2[k] <= '0;
            end
        end else begin
            r_tag1[0] <= '{vld: w_p1_vld, id: w_p1_id, zero: !w_p1_legal};
            r_tag2[0] <= '{vld: w_p2_vld, id: w_p2_id, zero: !w_p2_legal};
            for (int k = 1; k <= READ_LAT; k++) begin
                r_tag1[k] <= r_tag1[k-1];
                r_tag2[k] <= r_tag2[k-1];
            end
        end
    end

    // Capture SRAM data into the owning reader's slice as its tag reaches the end
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_data <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_tag1[READ_LAT-1].vld && r_tag1[READ_LAT-1].id == 2'(i))
                    r_rd_data[i*DW +: DW] <= r_tag1[READ_LAT-1].zero ? '0 : i_sram_rdata1;
                else if (r_tag2[READ_LAT-1].vld && r_tag2[READ_LAT-1].id == 2'(i))
                    r_rd_data[i*DW +: DW] <= r_tag2[READ_LAT-1].zero ? '0 : i_sram_rdata2;
            end
        end
    end

    // Valid pulses decoded from the last tag stage
    always_comb begin
        o_rd_valid = 3'b000;
        if (r_tag1[READ_LAT].vld) o_rd_valid[r_tag1[READ_LAT].id] = 1'b1;
        if (r_tag2[READ_LAT].vld) o_rd_valid[r_tag2[READ_LAT].id] = 1'b1;
    end

    assign o_wr_gnt      = w_wr_gnt;
    assign o_rd_gnt      = w_rd_gnt;
    assign o_rd_data     = r_rd_data;
    assign o_addr_err    = r_addr_err;
    assign o_sram_we     = r_sram_we;
    assign o_sram_waddr  = r_sram_waddr;
    assign o_sram_wdata  = r_sram_wdata;
    assign o_sram_raddr1 = r_sram_raddr1;
    assign o_sram_raddr2 = r_sram_raddr2;

endmodule
